// File: rtl/rpn_stack_sequencer_if.sv
// Token, result, stack and error signals between the RPN sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the source/stack/sink side.
interface rpn_stack_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 7
);
    logic              tok_valid;
    logic              tok_ready;
    logic              tok_is_op;
    logic [DATA_W-1:0] tok_data;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              stk_push;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_wdata;
    logic [DATA_W-1:0] stk_rdata;
    logic [CNT_W-1:0]  stk_count;
    logic              err_clr;
    logic [1:0]        err;

    modport master (
        input  tok_valid, tok_is_op, tok_data, res_ready, stk_rdata, stk_count, err_clr,
        output tok_ready, res_valid, res_data, stk_push, stk_pop, stk_wdata, err
    );

    modport slave (
        output tok_valid, tok_is_op, tok_data, res_ready, stk_rdata, stk_count, err_clr,
        input  tok_ready, res_valid, res_data, stk_push, stk_pop, stk_wdata, err
    );
endinterface

// File: rtl/rpn_stack_sequencer.sv
// Reverse-Polish command stage in front of a LIFO stack: pushes operands, pops and
// combines operands for operators, and emits popped values on a result stream.
module rpn_stack_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned CNT_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rpn_stack_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StPopB, StPopA, StCapA, StCap, StPushDup, StPush, StOut
    } state_e;

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpOr   = 3'd3;
    localparam logic [2:0] OpXor  = 3'd4;
    localparam logic [2:0] OpDup  = 3'd5;
    localparam logic [2:0] OpDrop = 3'd6;

    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TwoCnt  = CNT_W'(2);

    state_e            r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_res_data;
    logic              r_tok_ready;
    logic              r_res_valid;
    logic              r_stk_push;
    logic              r_stk_pop;
    logic [1:0]        r_err;

    logic              w_accept;
    logic [2:0]        w_opcode;
    logic              w_empty;
    logic              w_full;
    logic              w_lt2;
    logic [1:0]        w_err_set;
    logic              w_tok_ok;
    logic [DATA_W-1:0] w_alu;

    // tok_ready is only ever high in IDLE, so acceptance implies IDLE.
    assign w_accept = bus.tok_valid & r_tok_ready;
    assign w_opcode = bus.tok_data[2:0];
    assign w_empty  = (bus.stk_count == '0);
    assign w_full   = (bus.stk_count == FullCnt);
    assign w_lt2    = (bus.stk_count < TwoCnt);
    assign w_tok_ok = w_accept & (w_err_set == 2'b00);

    always_comb begin
        w_err_set = 2'b00;
        if (w_accept) begin
            if (!bus.tok_is_op) begin
                if (w_full) w_err_set[1] = 1'b1;
            end else begin
                unique case (w_opcode)
                    OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
                        if (w_lt2) w_err_set[0] = 1'b1;
                    end
                    OpDup: begin
                        if (w_empty) w_err_set[0] = 1'b1;
                        if (w_full)  w_err_set[1] = 1'b1;
                    end
                    default: begin
                        if (w_empty) w_err_set[0] = 1'b1;
                    end
                endcase
            end
        end
    end

    // a is the entry below top, arriving on stk_rdata in CAP_A; b was latched in POP_A.
    always_comb begin
        w_alu = '0;
        unique case (r_op)
            OpAdd:   w_alu = bus.stk_rdata + r_b;
            OpSub:   w_alu = bus.stk_rdata - r_b;
            OpAnd:   w_alu = bus.stk_rdata & r_b;
            OpOr:    w_alu = bus.stk_rdata | r_b;
            OpXor:   w_alu = bus.stk_rdata ^ r_b;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_op        <= '0;
            r_b         <= '0;
            r_wreg      <= '0;
            r_res_data  <= '0;
            r_tok_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_stk_push  <= 1'b0;
            r_stk_pop   <= 1'b0;
            r_err       <= 2'b00;
        end else begin
            // A new error in the same cycle as err_clr wins.
            r_err      <= (r_err & ~{2{bus.err_clr}}) | w_err_set;
            r_stk_push <= 1'b0;
            r_stk_pop  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_tok_ok) begin
                        r_tok_ready <= 1'b0;
                        if (!bus.tok_is_op) begin
                            r_wreg     <= bus.tok_data;
                            r_stk_push <= 1'b1;
                            r_state    <= StPush;
                        end else begin
                            r_op      <= w_opcode;
                            r_stk_pop <= 1'b1;
                            r_state   <= StPopB;
                        end
                    end else begin
                        r_tok_ready <= 1'b1;
                    end
                end
                StPopB: begin
                    if (r_op == OpDrop) begin
                        r_tok_ready <= 1'b1;
                        r_state     <= StIdle;
                    end else if (r_op > OpDrop || r_op == OpDup) begin
                        r_state <= StCap;
                    end else begin
                        r_stk_pop <= 1'b1;
                        r_state   <= StPopA;
                    end
                end
                StPopA: begin
                    r_b     <= bus.stk_rdata;
                    r_state <= StCapA;
                end
                StCapA: begin
                    r_wreg     <= w_alu;
                    r_stk_push <= 1'b1;
                    r_state    <= StPush;
                end
                StCap: begin
                    if (r_op == OpDup) begin
                        r_wreg     <= bus.stk_rdata;
                        r_stk_push <= 1'b1;
                        r_state    <= StPushDup;
                    end else begin
                        r_res_data  <= bus.stk_rdata;
                        r_res_valid <= 1'b1;
                        r_state     <= StOut;
                    end
                end
                StPushDup: begin
                    r_stk_push <= 1'b1;
                    r_state    <= StPush;
                end
                StPush: begin
                    r_tok_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                StOut: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_tok_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_tok_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign bus.tok_ready = r_tok_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.stk_push  = r_stk_push;
    assign bus.stk_pop   = r_stk_pop;
    assign bus.stk_wdata = r_wreg;
    assign bus.err       = r_err;

endmodule
